// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared status codes and FSM state encoding for seq_detector_param
package seqdet_pkg;
   localparam logic [7:0] IDLE_CODE_DEF  = 8'b01010101;
   localparam logic [7:0] MATCH_CODE_DEF = 8'b10101010;
   typedef enum logic [1:0] {FILL, ARMED, HIT} state_e;
endpackage

// File: rtl/seqdet_hist.sv
// seqdet_hist: serial history shift register with saturating fill count
module seqdet_hist #(
   parameter int PAT_LEN = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               shift_i,
   input  logic               bit_i,
   input  logic               clr_i,
   input  logic               restart_i,
   output logic [PAT_LEN-1:0] hist_nxt_o,
   output logic               full_o
);
   localparam int FW = $clog2(PAT_LEN + 1);
   localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
   logic [PAT_LEN-1:0] hist_q;
   logic [FW-1:0]      fill_q, fill_d;
   always_comb begin
      hist_nxt_o = shift_i ? {hist_q[PAT_LEN-2:0], bit_i} : hist_q;
      fill_d     = (shift_i && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
      full_o     = fill_d == FULL;
   end
   // restart drops only the fill count so a full fresh pattern is required
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_nxt_o;
         fill_q <= restart_i ? '0 : fill_d;
      end
   end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: loadable serial pattern detector; match counter present only with SEQDET_CNT_EN
module seq_detector_param
   import seqdet_pkg::*;
#(
   parameter int                 PAT_LEN     = 4,
   parameter logic [PAT_LEN-1:0] DEFAULT_PAT = PAT_LEN'(4'b1011),
   parameter int                 OUT_W       = 8,
   parameter logic [OUT_W-1:0]   IDLE_CODE   = OUT_W'(IDLE_CODE_DEF),
   parameter logic [OUT_W-1:0]   MATCH_CODE  = OUT_W'(MATCH_CODE_DEF),
   parameter int                 CNT_W       = 8
) (
   input  logic               CK,
   input  logic               R,
   input  logic               IN,
   input  logic               IN_VALID,
   input  logic               OVERLAP,
   input  logic               PAT_LOAD,
   input  logic [PAT_LEN-1:0] PAT_IN,
   output logic [OUT_W-1:0]   OUT,
   output logic               MATCH,
   output logic [CNT_W-1:0]   MATCH_CNT
);
   logic [PAT_LEN-1:0] pat_q, hist_nxt;
   logic [OUT_W-1:0]   out_q, out_d;
   state_e             state_q, state_d;
   logic               acc, full, hit;

   seqdet_hist #(.PAT_LEN(PAT_LEN)) u_hist (
      .clk_i     (CK),
      .rst_i     (R),
      .shift_i   (acc),
      .bit_i     (IN),
      .clr_i     (PAT_LOAD),
      .restart_i (hit && !OVERLAP),
      .hist_nxt_o(hist_nxt),
      .full_o    (full)
   );

   always_comb begin
      acc     = IN_VALID && !PAT_LOAD;
      hit     = acc && full && hist_nxt == pat_q;
      state_d = PAT_LOAD ? FILL : hit ? HIT : full ? ARMED : FILL;
      out_d   = hit ? MATCH_CODE : IDLE_CODE;
   end

   always_ff @(posedge CK) begin
      if (R) begin
         pat_q   <= DEFAULT_PAT;
         state_q <= FILL;
         out_q   <= IDLE_CODE;
      end else begin
         if (PAT_LOAD) pat_q <= PAT_IN;
         state_q <= state_d;
         out_q   <= out_d;
      end
   end

   assign OUT   = out_q;
   assign MATCH = state_q == HIT;

`ifdef SEQDET_CNT_EN
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge CK) begin
      if (R) cnt_q <= '0;
      else if (hit && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
   end
   assign MATCH_CNT = cnt_q;
`else
   assign MATCH_CNT = '0;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of seq_detector_param with a 2-bit match counter
module tb_seq_detector_param;
   logic       CK = 0, R = 0, IN = 0, IN_VALID = 0, OVERLAP = 0, PAT_LOAD = 0;
   logic [3:0] PAT_IN = '0;
   logic [7:0] OUT;
   logic       MATCH;
   logic [1:0] MATCH_CNT;
   int         checks = 0, errors = 0;
`ifdef SEQDET_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   seq_detector_param #(.CNT_W(2)) dut (
      .CK(CK), .R(R), .IN(IN), .IN_VALID(IN_VALID), .OVERLAP(OVERLAP),
      .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN), .OUT(OUT), .MATCH(MATCH), .MATCH_CNT(MATCH_CNT)
   );

   always #5 CK = ~CK;

   function automatic logic [1:0] cnt_exp(input int n);
      return CNT_EN ? ((n > 3) ? 2'd3 : 2'(n)) : 2'd0;
   endfunction

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   task automatic send(input logic b);
      IN_VALID = 1; IN = b;
      tick();
      IN_VALID = 0;
   endtask

   task automatic do_reset();
      R = 1;
      tick();
      R = 0;
   endtask

   task automatic load(input logic [3:0] p);
      PAT_LOAD = 1; PAT_IN = p;
      tick();
      PAT_LOAD = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (OUT !== 8'h55) begin errors++; $display("FAIL reset_out got %h exp 55", OUT); end
      checks++;
      if (MATCH !== 1'b0) begin errors++; $display("FAIL reset_match got %b exp 0", MATCH); end
      checks++;
      if (MATCH_CNT !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", MATCH_CNT); end
   endtask

   task automatic test_basic();
      logic [3:0] seq = 4'b1011;
      do_reset();
      OVERLAP = 0;
      for (int i = 0; i < 4; i++) begin
         send(seq[3-i]);
         checks++;
         if (MATCH !== (i == 3)) begin errors++; $display("FAIL basic_match bit %0d got %b exp %b", i, MATCH, i == 3); end
         checks++;
         if (OUT !== ((i == 3) ? 8'hAA : 8'h55)) begin errors++; $display("FAIL basic_out bit %0d got %h", i, OUT); end
      end
      checks++;
      if (MATCH_CNT !== cnt_exp(1)) begin errors++; $display("FAIL basic_cnt got %0d exp %0d", MATCH_CNT, cnt_exp(1)); end
      tick();
      checks++;
      if (MATCH !== 1'b0 || OUT !== 8'h55) begin errors++; $display("FAIL basic_after got %b/%h exp 0/55", MATCH, OUT); end
   endtask

   task automatic run_stream(input logic ov, input logic [6:0] exp_m, input int n_exp);
      logic [6:0] seq = 7'b1011011;
      do_reset();
      OVERLAP = ov;
      for (int i = 0; i < 7; i++) begin
         send(seq[6-i]);
         checks++;
         if (MATCH !== exp_m[6-i]) begin errors++; $display("FAIL stream_ov%0b bit %0d got %b exp %b", ov, i, MATCH, exp_m[6-i]); end
         checks++;
         if (OUT !== (exp_m[6-i] ? 8'hAA : 8'h55)) begin errors++; $display("FAIL stream_out_ov%0b bit %0d got %h", ov, i, OUT); end
      end
      checks++;
      if (MATCH_CNT !== cnt_exp(n_exp)) begin errors++; $display("FAIL stream_cnt_ov%0b got %0d exp %0d", ov, MATCH_CNT, cnt_exp(n_exp)); end
   endtask

   task automatic test_overlap();
      run_stream(1'b1, 7'b0001001, 2);
      run_stream(1'b0, 7'b0001000, 1);
   endtask

   task automatic test_gaps();
      do_reset();
      OVERLAP = 0;
      send(1); send(0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (MATCH !== 1'b0) begin errors++; $display("FAIL gap_idle %0d got %b exp 0", i, MATCH); end
      end
      send(1);
      checks++;
      if (MATCH !== 1'b0) begin errors++; $display("FAIL gap_early got %b exp 0", MATCH); end
      send(1);
      checks++;
      if (MATCH !== 1'b1 || OUT !== 8'hAA) begin errors++; $display("FAIL gap_match got %b/%h exp 1/aa", MATCH, OUT); end
   endtask

   task automatic test_load();
      do_reset();
      OVERLAP = 0;
      IN_VALID = 1; IN = 1;
      load(4'b1111);
      IN_VALID = 0;
      checks++;
      if (MATCH !== 1'b0) begin errors++; $display("FAIL load_cycle got %b exp 0", MATCH); end
      for (int i = 0; i < 4; i++) begin
         send(1);
         checks++;
         if (MATCH !== (i == 3)) begin errors++; $display("FAIL load_ones bit %0d got %b exp %b", i, MATCH, i == 3); end
      end
      send(1); send(0); send(1); send(1);
      checks++;
      if (MATCH !== 1'b0) begin errors++; $display("FAIL load_oldpat got %b exp 0", MATCH); end
      checks++;
      if (MATCH_CNT !== cnt_exp(1)) begin errors++; $display("FAIL load_cnt got %0d exp %0d", MATCH_CNT, cnt_exp(1)); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      OVERLAP = 0;
      send(1); send(0); send(1);
      R = 1; IN_VALID = 1; IN = 1;
      tick();
      R = 0; IN_VALID = 0;
      send(1);
      checks++;
      if (MATCH !== 1'b0 || OUT !== 8'h55) begin errors++; $display("FAIL midreset got %b/%h exp 0/55", MATCH, OUT); end
      checks++;
      if (MATCH_CNT !== 2'd0) begin errors++; $display("FAIL midreset_cnt got %0d exp 0", MATCH_CNT); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] exp_m = 6'b000111;
      do_reset();
      OVERLAP = 1;
      load(4'b1111);
      for (int i = 0; i < 6; i++) begin
         send(1);
         checks++;
         if (MATCH !== exp_m[5-i]) begin errors++; $display("FAIL b2b bit %0d got %b exp %b", i, MATCH, exp_m[5-i]); end
      end
   endtask

   task automatic test_saturate();
      do_reset();
      OVERLAP = 1;
      load(4'b1111);
      for (int i = 0; i < 8; i++) send(1);
      checks++;
      if (MATCH_CNT !== cnt_exp(5)) begin errors++; $display("FAIL sat_cnt got %0d exp %0d", MATCH_CNT, cnt_exp(5)); end
      tick();
      checks++;
      if (MATCH_CNT !== cnt_exp(5)) begin errors++; $display("FAIL sat_hold got %0d exp %0d", MATCH_CNT, cnt_exp(5)); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overlap();
      test_gaps();
      test_load();
      test_reset_mid();
      test_back_to_back();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
